// File: rtl/adc_sim.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | adc_sim : behavioural 8-bit ADC answering a req/rdy four-phase          |
// |           handshake with a repeatable triangle waveform.                |
// |           Optional ADC_SPIKE_EN replaces one conversion with a spike.   |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module adc_sim #(
  parameter int unsigned         DATA_W      = 8,
  parameter int unsigned         CONV_CYCLES = 4,
  parameter logic [DATA_W-1:0]   LOW         = 8'h20,
  parameter logic [DATA_W-1:0]   HIGH        = 8'h60,
  parameter logic [DATA_W-1:0]   STEP        = 8'h10,
  parameter logic [15:0]         SPIKE_IDX   = 16'd10,
  parameter logic [DATA_W-1:0]   SPIKE_VAL   = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  output logic              rdy_o,
  output logic [DATA_W-1:0] dat_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0]   wave_q, wave_d;
  logic                dir_dn_q, dir_dn_d;
  logic [15:0]         conv_cnt_q, conv_cnt_d;
  logic                rdy_q, rdy_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic                busy_q, busy_d;

  logic [DATA_W:0]     w_up_sum;
  logic [DATA_W:0]     w_dn_diff;
  logic [DATA_W-1:0]   w_sample;
  logic                w_complete;

  // One extra bit so the step can never wrap past the rails.
  assign w_up_sum   = {1'b0, wave_q} + {1'b0, STEP};
  assign w_dn_diff  = {1'b0, wave_q} - {1'b0, STEP};
  assign w_complete = (state_q == S_CONV) && req_i && (lat_cnt_q == 8'd0);

`ifdef ADC_SPIKE_EN
  logic spiked_q;
  logic w_spike;

  // The flag keeps a saturated counter from spiking more than once.
  assign w_spike  = (conv_cnt_q == SPIKE_IDX) && !spiked_q;
  assign w_sample = w_spike ? SPIKE_VAL : wave_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spiked_q <= 1'b0;
    end else if (w_complete && w_spike) begin
      spiked_q <= 1'b1;
    end
  end
`else
  logic unused_spike;
  assign unused_spike = ^{SPIKE_IDX, SPIKE_VAL};
  assign w_sample     = wave_q;
`endif

  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    wave_d     = wave_q;
    dir_dn_d   = dir_dn_q;
    conv_cnt_d = conv_cnt_q;
    rdy_d      = rdy_q;
    dat_d      = dat_q;
    busy_d     = busy_q;
    case (state_q)
      S_IDLE: begin
        rdy_d = 1'b0;
        if (req_i) begin
          state_d   = S_CONV;
          lat_cnt_d = 8'(CONV_CYCLES - 1);
          busy_d    = 1'b1;
        end
      end
      S_CONV: begin
        if (!req_i) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (lat_cnt_q != 8'd0) begin
          lat_cnt_d = lat_cnt_q - 8'd1;
        end else begin
          state_d = S_DONE;
          dat_d   = w_sample;
          rdy_d   = 1'b1;
          busy_d  = 1'b0;
          if (conv_cnt_q != 16'hFFFF) begin
            conv_cnt_d = conv_cnt_q + 16'd1;
          end
          if (!dir_dn_q) begin
            if (w_up_sum >= {1'b0, HIGH}) begin
              wave_d   = HIGH;
              dir_dn_d = 1'b1;
            end else begin
              wave_d   = w_up_sum[DATA_W-1:0];
            end
          end else begin
            if ($signed(w_dn_diff) <= $signed({1'b0, LOW})) begin
              wave_d   = LOW;
              dir_dn_d = 1'b0;
            end else begin
              wave_d   = w_dn_diff[DATA_W-1:0];
            end
          end
        end
      end
      S_DONE: begin
        if (!req_i) begin
          state_d = S_IDLE;
          rdy_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        rdy_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lat_cnt_q  <= 8'd0;
      wave_q     <= LOW;
      dir_dn_q   <= 1'b0;
      conv_cnt_q <= 16'd0;
      rdy_q      <= 1'b0;
      dat_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      wave_q     <= wave_d;
      dir_dn_q   <= dir_dn_d;
      conv_cnt_q <= conv_cnt_d;
      rdy_q      <= rdy_d;
      dat_q      <= dat_d;
      busy_q     <= busy_d;
    end
  end

  assign rdy_o  = rdy_q;
  assign dat_o  = dat_q;
  assign busy_o = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_sim.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_adc_sim : self-checking bench for adc_sim (default parameters).     |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_adc_sim;

  localparam int CONV = 4;
  localparam int LO   = 'h20;
  localparam int HI   = 'h60;
  localparam int ST   = 'h10;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic       rdy;
  logic       busy;
  logic [7:0] dat;

  always #5 clk = ~clk;

  adc_sim dut (
    .clk    (clk),
    .rst    (rst),
    .req_i  (req),
    .rdy_o  (rdy),
    .dat_o  (dat),
    .busy_o (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int period[$];
  int conv_idx = 0;

  typedef struct {
    int         hold;
    logic [7:0] exp_dat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One full period of the triangle, built directly from its rise/fall rules.
  task automatic build_period();
    int v;
    period.delete();
    v = LO;
    forever begin
      if (v >= HI) begin
        period.push_back(HI);
        break;
      end
      period.push_back(v);
      v = v + ST;
    end
    v = HI - ST;
    while (v > LO) begin
      period.push_back(v);
      v = v - ST;
    end
  endtask

  function automatic logic [7:0] exp_sample(input int idx);
`ifdef ADC_SPIKE_EN
    if (idx == 10) return 8'hFF;
`endif
    return 8'(period[idx % period.size()]);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    conv_idx = 0;
    #1;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    repeat (n) begin
      @(posedge clk); #1;
      check({tag, "_idle"}, {rdy, busy}, 2'b00);
    end
  endtask

  task automatic handshake(input int hold, output logic [7:0] got);
    logic [7:0] exp;
    int k;
    exp = exp_sample(conv_idx);
    req = 1'b1;
    @(posedge clk); #1;
    check("hs_busy_start", {rdy, busy}, 2'b01);
    k = 0;
    while (!rdy && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("hs_latency", k, CONV);
    check("hs_done_flags", {rdy, busy}, 2'b10);
    check("hs_dat", dat, exp);
    got = dat;
    conv_idx++;
    repeat (hold) begin
      @(posedge clk); #1;
      check("hs_hold", {rdy, busy, dat}, {2'b10, exp});
    end
    req = 1'b0;
    @(posedge clk); #1;
    check("hs_drop", {rdy, busy, dat}, {2'b00, exp});
  endtask

  task automatic abort_conv(input int a);
    req = 1'b1;
    @(posedge clk); #1;
    repeat (a) begin
      @(posedge clk); #1;
    end
    req = 1'b0;
    @(posedge clk); #1;
    check("abort_flags", {rdy, busy}, 2'b00);
    idle_cycles(2, "abort");
  endtask

  vec_t       vecs[6];
  logic [7:0] got;
  logic [7:0] spike_got[12];

  initial begin
    vecs[0] = '{hold: 0,  exp_dat: 8'h20};
    vecs[1] = '{hold: 10, exp_dat: 8'h30};
    vecs[2] = '{hold: 1,  exp_dat: 8'h40};
    vecs[3] = '{hold: 3,  exp_dat: 8'h50};
    vecs[4] = '{hold: 0,  exp_dat: 8'h60};
    vecs[5] = '{hold: 2,  exp_dat: 8'h50};

    build_period();
    rst = 1'b1;
    req = 1'b0;
    #1;
    check("reset_outputs", {rdy, busy, dat}, 10'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    conv_idx = 0;

    // Idle with req low: nothing moves.
    repeat (20) begin
      @(posedge clk); #1;
      check("idle_outputs", {rdy, busy, dat}, 10'h0);
    end

    // Table of six handshakes from reset.
    for (int i = 0; i < 6; i++) begin
      handshake(vecs[i].hold, got);
      check("table_dat", got, vecs[i].exp_dat);
    end

    // Abort two cycles into CONV after reset; next sample still LOW.
    do_reset();
    abort_conv(2);
    handshake(0, got);
    check("after_abort_dat", got, 8'h20);

    // Reset one cycle into DONE clears outputs before the next edge.
    handshake(0, got);
    req = 1'b1;
    repeat (1 + CONV) begin
      @(posedge clk); #1;
    end
    check("pre_reset_rdy", rdy, 1'b1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_reset", {rdy, busy, dat}, 10'h0);
    req = 1'b0;
    #1;
    rst = 1'b0;
    conv_idx = 0;
    idle_cycles(2, "post_reset");
    handshake(0, got);
    check("after_reset_dat", got, 8'h20);

    // Twelve conversions from reset: index 10/11 behaviour.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      handshake(0, spike_got[i]);
    end
`ifdef ADC_SPIKE_EN
    check("spike_idx10", spike_got[10], 8'hFF);
`else
    check("tri_idx10", spike_got[10], 8'h40);
`endif
    check("tri_idx11", spike_got[11], 8'h50);

    // Randomised gaps, holds and aborts against the model.
    for (int i = 0; i < 30; i++) begin
      idle_cycles($urandom_range(0, 3), "rand");
      if ($urandom_range(0, 3) == 0) begin
        abort_conv($urandom_range(0, CONV - 1));
      end else begin
        handshake($urandom_range(0, 4), got);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // rdy and busy must never be high together.
  always @(negedge clk) begin
    if (rdy && busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL rdy_busy_exclusive: got rdy=%0b busy=%0b, expected not both 1", rdy, busy);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
